// File: rtl/minibus_pkg.sv
// minibus_pkg
//   Shared Mini-Bus types: the request/response structs seen by every master
//   and slave, and the state encoding of the round-robin bus arbiter.
//   Also provides a helper that tells whether a request is active.
package minibus_pkg;

  localparam int MB_ADDR_W = 32;
  localparam int MB_DATA_W = 32;

  // Access width codes carried in minibus_req_t.width
  localparam logic [1:0] MB_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] MB_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MB_WIDTH_WORD = 2'd2;

  typedef struct packed {
    logic                 wen;
    logic                 ren;
    logic [1:0]           width;
    logic [MB_ADDR_W-1:0] addr;
    logic [MB_DATA_W-1:0] wdata;
  } minibus_req_t;

  typedef struct packed {
    logic                 ack;
    logic                 err;
    logic [MB_DATA_W-1:0] rdata;
  } minibus_res_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } minibus_arb_state_t;

  // A request is live when either strobe is high; both high still counts.
  function automatic logic mb_is_req(input minibus_req_t r);
    return r.wen | r.ren;
  endfunction

endpackage

// File: rtl/minibus_rr_picker.sv
// minibus_rr_picker
//   Combinational round-robin selector: returns the first requester at or
//   after ptr, wrapping modulo N.
//   Ports:
//     req   [N-1:0]          request vector
//     ptr   [$clog2(N)-1:0]  highest-priority position
//     pick  [N-1:0]          one-hot winner (zero when nothing requests)
//     valid                  at least one request present
module minibus_rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         pick,
  output logic                 valid
);

  logic [N-1:0] rot_s;
  logic [N-1:0] oh_rot_s;

  // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_s    = N'({req, req} >> ptr);
    oh_rot_s = rot_s & (~rot_s + N'(1));
    pick     = N'(({oh_rot_s, oh_rot_s} << ptr) >> N);
    valid    = |req;
  end

endmodule

// File: rtl/minibus_arbiter.sv
// minibus_arbiter
//   Round-robin arbiter sharing one Mini-Bus master port between N_MASTERS
//   requesters. A grant is held until the slave acks or the master aborts,
//   and every transaction is followed by one IDLE cycle.
//   Optional build macro MINIBUS_ARB_TIMEOUT_EN adds a bus-error timeout
//   after TIMEOUT_CYCLES BUSY cycles without ack.
//   Ports:
//     clk, nrst  clock, asynchronous active-low reset
//     m_req      per-master requests           m_res  per-master responses
//     s_req      request to the slave fabric   s_res  slave response
//     grant      one-hot granted master        busy   high while BUSY
module minibus_arbiter
  import minibus_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  minibus_req_t [N_MASTERS-1:0] m_req,
  output minibus_res_t [N_MASTERS-1:0] m_res,
  output minibus_req_t                 s_req,
  input  minibus_res_t                 s_res,
  output logic [N_MASTERS-1:0]         grant,
  output logic                         busy
);

  localparam int PW = $clog2(N_MASTERS);

  minibus_arb_state_t   state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]        idx_q, idx_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

  logic [N_MASTERS-1:0] req_vec_s;
  logic [N_MASTERS-1:0] pick_s;
  logic                 pick_vld_s;
  logic [PW-1:0]        pick_idx_s;
  logic [PW-1:0]        rr_next_s;
  minibus_req_t         gnt_req_s;
  logic                 release_s;
  logic                 timeout_hit_s;

  // Request vector, one-hot to index conversion and next pointer.
  always_comb begin
    req_vec_s  = '0;
    pick_idx_s = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      req_vec_s[i] = mb_is_req(m_req[i]);
      pick_idx_s   = pick_idx_s | (pick_s[i] ? PW'(i) : '0);
    end
    rr_next_s = (idx_q == PW'(N_MASTERS - 1)) ? '0 : idx_q + 1'b1;
    gnt_req_s = m_req[idx_q];
  end

  minibus_rr_picker #(
    .N (N_MASTERS)
  ) u_picker (
    .req   (req_vec_s),
    .ptr   (rr_ptr_q),
    .pick  (pick_s),
    .valid (pick_vld_s)
  );

`ifdef MINIBUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Count BUSY cycles without ack; zero outside BUSY so every grant starts clean.
  always_comb begin
    if (state_q == ARB_BUSY && !s_res.ack) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_d = '0;
    end
  end

  assign timeout_hit_s = (state_q == ARB_BUSY) && (tmo_cnt_q == CW'(TIMEOUT_CYCLES));

  // Timeout counter register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state logic plus the combinational bus passthrough.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    release_s = 1'b0;
    s_req     = '0;
    m_res     = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld_s) begin
          state_d = ARB_BUSY;
          grant_d = pick_s;
          idx_d   = pick_idx_s;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        s_req         = gnt_req_s;
        m_res[idx_q]  = s_res;
        // A real ack beats both the timeout and an abort in the same cycle.
        if (s_res.ack) begin
          release_s = 1'b1;
        end else if (timeout_hit_s) begin
          s_req        = '0;
          m_res[idx_q] = '{ack: 1'b1, err: 1'b1, rdata: '0};
          release_s    = 1'b1;
        end else if (!mb_is_req(gnt_req_s)) begin
          release_s = 1'b1;
        end else begin
          release_s = 1'b0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
    if (release_s) begin
      state_d  = ARB_IDLE;
      grant_d  = '0;
      rr_ptr_d = rr_next_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Arbiter state, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_minibus_arbiter.sv
// tb_minibus_arbiter
//   Directed scenarios plus randomized traffic for minibus_arbiter (N=4),
//   compared every cycle against a rule-level reference model that tracks
//   only "who owns the bus" and "who is next in line".
module tb_minibus_arbiter;
  import minibus_pkg::*;

  localparam int N  = 4;
  localparam int TO = 4;

  logic                 clk  = 1'b0;
  logic                 nrst = 1'b1;
  minibus_req_t [N-1:0] m_req;
  minibus_res_t [N-1:0] m_res;
  minibus_req_t         s_req;
  minibus_res_t         s_res;
  logic [N-1:0]         grant;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           owner;    // -1 when the bus is idle
  int           ptr;
  int           bcnt;
  logic [N-1:0] ack_prev;

  logic [31:0]  slave_reg [4];

  always #5 clk = ~clk;

  minibus_arbiter #(
    .N_MASTERS      (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .nrst  (nrst),
    .m_req (m_req),
    .m_res (m_res),
    .s_req (s_req),
    .s_res (s_res),
    .grant (grant),
    .busy  (busy)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare DUT outputs with the model, then advance the model by one clock.
  task automatic settle();
    logic [N-1:0]         eg;
    minibus_req_t         es;
    minibus_res_t [N-1:0] er;
    logic                 eb;
    logic                 tmo;
    logic                 found;
    int                   m;
    #1;
    eg  = '0;
    es  = '0;
    er  = '0;
    eb  = 1'b0;
    tmo = 1'b0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      eb        = 1'b1;
      es        = m_req[owner];
      er[owner] = s_res;
`ifdef MINIBUS_ARB_TIMEOUT_EN
      if (!s_res.ack && bcnt == TO) begin
        tmo             = 1'b1;
        es              = '0;
        er[owner].ack   = 1'b1;
        er[owner].err   = 1'b1;
        er[owner].rdata = '0;
      end
`endif
    end
    check("grant", 256'(grant), 256'(eg));
    check("busy",  256'(busy),  256'(eb));
    check("s_req", 256'(s_req), 256'(es));
    check("m_res", 256'(m_res), 256'(er));
    for (int i = 0; i < N; i++) ack_prev[i] = er[i].ack;
    if (owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        m = (ptr + k) % N;
        if (!found && (m_req[m].wen || m_req[m].ren)) begin
          owner = m;
          found = 1'b1;
        end
      end
      bcnt = 0;
    end else if (s_res.ack || tmo || !(m_req[owner].wen || m_req[owner].ren)) begin
      ptr   = (owner + 1) % N;
      owner = -1;
    end else begin
      bcnt++;
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    check("rst_grant", 256'(grant), 256'(0));
    check("rst_busy",  256'(busy),  256'(0));
    check("rst_s_req", 256'(s_req), 256'(0));
    check("rst_m_res", 256'(m_res), 256'(0));
    m_req = '0;
    s_res = '0;
    repeat (2) @(posedge clk);
    #1;
    nrst     = 1'b1;
    owner    = -1;
    ptr      = 0;
    bcnt     = 0;
    ack_prev = '0;
    settle();
  endtask

  function automatic minibus_req_t mk_read(input logic [31:0] addr);
    minibus_req_t r;
    r       = '0;
    r.ren   = 1'b1;
    r.width = MB_WIDTH_WORD;
    r.addr  = addr;
    return r;
  endfunction

  // One randomized cycle: masters hold until acked, may start or abort.
  task automatic rand_cycle(input int start_pct, input int abort_pct, input int ack_pct);
    logic [1:0] op;
    step();
    for (int i = 0; i < N; i++) begin
      if (m_req[i].wen || m_req[i].ren) begin
        if (ack_prev[i] || ($urandom_range(99) < abort_pct)) begin
          m_req[i].wen = 1'b0;
          m_req[i].ren = 1'b0;
        end
      end else if ($urandom_range(99) < start_pct) begin
        op             = 2'($urandom_range(3, 1));
        m_req[i].wen   = op[0];
        m_req[i].ren   = op[1];
        m_req[i].width = 2'($urandom_range(2));
        m_req[i].addr  = $urandom;
        m_req[i].wdata = $urandom;
      end
    end
    s_res.ack   = ($urandom_range(99) < ack_pct);
    s_res.err   = ($urandom_range(7) == 0);
    s_res.rdata = $urandom;
    settle();
  endtask

  logic [N-1:0] one_v;
  int           gi;

  initial begin
    m_req = '0;
    s_res = '0;
    for (int i = 0; i < 4; i++) slave_reg[i] = 32'h0;

    // Reset state and single-master write latency
    do_reset();
    step();
    m_req[0]       = '0;
    m_req[0].wen   = 1'b1;
    m_req[0].width = MB_WIDTH_WORD;
    m_req[0].addr  = 32'h4;
    m_req[0].wdata = 32'hDEADBEEF;
    settle();
    step(); settle();
    check("lat_grant_c1", 256'(grant), 256'(4'b0001));
    step();
    s_res.ack = 1'b1;
    if (s_req.wen) slave_reg[s_req.addr[3:2]] = s_req.wdata;
    settle();
    check("lat_ack_c2", 256'(m_res[0].ack), 256'(1));
    check("lat_others", 256'(m_res[N-1:1]), 256'(0));
    step();
    m_req = '0;
    s_res = '0;
    settle();
    check("lat_sreq_c3", 256'(s_req), 256'(0));
    check("slave_reg1", 256'(slave_reg[1]), 256'(32'hDEADBEEF));

    // Contention: m0 then m1, one idle cycle between, pointer ends at 2
    do_reset();
    step();
    m_req[0]  = mk_read(32'h10);
    m_req[1]  = mk_read(32'h20);
    s_res.ack = 1'b1;
    settle();
    step(); settle();
    check("cont_g0", 256'(grant), 256'(4'b0001));
    step(); m_req[0] = '0; settle();
    check("cont_gap", 256'(grant), 256'(4'b0000));
    step(); settle();
    check("cont_g1", 256'(grant), 256'(4'b0010));
    step(); m_req[1] = '0; m_req[0] = mk_read(32'h0); m_req[3] = mk_read(32'hC); settle();
    step(); settle();
    check("cont_ptr", 256'(grant), 256'(4'b1000));

    // Fairness: all masters request continuously, acked every BUSY cycle
    do_reset();
    step();
    for (int i = 0; i < N; i++) m_req[i] = mk_read(32'(i * 4));
    s_res.ack = 1'b1;
    settle();
    gi = 0;
    for (int c = 0; c < 40 && gi < 8; c++) begin
      step(); settle();
      if (grant != '0) begin
        one_v        = '0;
        one_v[gi % N] = 1'b1;
        check("fair_order", 256'(grant), 256'(one_v));
        gi++;
      end
    end
    check("fair_count", 256'(gi), 256'(8));

    // Abort: m1 drops its read before ack, then m0 gets the bus
    do_reset();
    step(); m_req[1] = mk_read(32'h8); settle();
    step(); settle();
    check("abort_g1", 256'(grant), 256'(4'b0010));
    step(); m_req[1].ren = 1'b0; m_req[0] = mk_read(32'h0); settle();
    check("abort_noack", 256'(m_res[1].ack), 256'(0));
    step(); settle();
    check("abort_idle", 256'(grant), 256'(4'b0000));
    step(); settle();
    check("abort_g0", 256'(grant), 256'(4'b0001));

    // Reset in the middle of a transaction, then restart from master 0
    step(); m_req[0] = '0; m_req[2] = mk_read(32'h8); s_res = '0; settle();
    step(); settle();
    step(); settle();
    check("mid_busy", 256'(busy), 256'(1));
    step();
    do_reset();
    step(); m_req[0] = mk_read(32'h0); m_req[2] = mk_read(32'h8); settle();
    step(); settle();
    check("post_rst_g0", 256'(grant), 256'(4'b0001));

`ifdef MINIBUS_ARB_TIMEOUT_EN
    // Unmapped address: no ack ever, expect an error response after TO cycles
    do_reset();
    step(); m_req[0] = mk_read(32'hFFFF_0000); settle();
    for (int c = 0; c < TO; c++) begin
      step(); settle();
      check("tmo_wait", 256'(m_res[0]), 256'(0));
    end
    step(); settle();
    check("tmo_resp", 256'(m_res[0]), 256'({1'b1, 1'b1, 32'h0}));
    step(); m_req[0] = '0; settle();
    check("tmo_idle", 256'(grant), 256'(0));
`endif

    // Randomized traffic in a few flavours
    do_reset();
    for (int c = 0; c < 1500; c++) rand_cycle(30, 3, 40);
    for (int c = 0; c < 1500; c++) rand_cycle(90, 0, 20);
    for (int c = 0; c < 1000; c++) rand_cycle(50, 10, 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
